// File: rtl/mem_stage.sv
// Memory-access stage of the RV64 pipeline: latches the EX bundle, runs the
// data-memory handshake, lane-shifts stores and extends loads into the WB bundle.
module mem_stage #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [10:0]       ex_mem_onehot,
    input  logic [31:0]       ex_pc,
    input  logic              ex_ebreak,
    input  logic              ex_we,
    input  logic [4:0]        ex_rd,
    input  logic [63:0]       ex_result,
    input  logic [63:0]       ex_wdata,
    output logic              mem_stall,
    output logic              dmem_req,
    input  logic              dmem_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_wen,
    output logic [7:0]        dmem_be,
    output logic [63:0]       dmem_wdata,
    input  logic              dmem_rvalid,
    input  logic [63:0]       dmem_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_pc,
    output logic              wb_ebreak,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [63:0]       wb_data,
    output logic              fwd_we,
    output logic [4:0]        fwd_rd,
    output logic [63:0]       fwd_data,
    output logic              mem_err
);

    // Onehot bit order: {lwu,sh,sd,sw,ld,lw,lhu,lh,lbu,lb,sb}
    localparam logic [10:0] M_BYTE  = 11'b000_0000_0111;
    localparam logic [10:0] M_HALF  = 11'b010_0001_1000;
    localparam logic [10:0] M_WORD  = 11'b100_1010_0000;
    localparam logic [10:0] M_DW    = 11'b001_0100_0000;
    localparam logic [10:0] M_STORE = 11'b011_1000_0001;
    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state, state_nxt;
    logic [10:0] op_q;
    logic [31:0] pc_q;
    logic        ebreak_q;
    logic        we_q;
    logic [4:0]  rd_q;
    logic [63:0] res_q;
    logic [63:0] wd_q;
    logic [7:0]  cnt;
    logic        done;
    logic        timeout;
    logic [2:0]  off;
    logic [63:0] sh_b;
    logic [63:0] sh_h;
    logic [31:0] word;
    logic [63:0] load_val;

    assign off = res_q[2:0];

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: if (ex_valid && (|ex_mem_onehot)) state_nxt = S_REQ;
            S_REQ: begin
                if (dmem_ready) state_nxt = S_WAIT;
                else if (cnt >= CNT_LAST) begin
                    state_nxt = S_IDLE;
                    timeout   = 1'b1;
                end
            end
            S_WAIT: begin
                // A response arriving on the deadline cycle still completes normally
                if (dmem_rvalid) begin
                    state_nxt = S_IDLE;
                    done      = 1'b1;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = S_IDLE;
                    timeout   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dmem_be    = 8'h00;
        dmem_wdata = 64'h0;
        if (|(op_q & M_BYTE)) begin
            dmem_be    = 8'h01 << off;
            dmem_wdata = {56'h0, wd_q[7:0]} << {off, 3'b000};
        end else if (|(op_q & M_HALF)) begin
            dmem_be    = 8'h03 << {off[2:1], 1'b0};
            dmem_wdata = {48'h0, wd_q[15:0]} << {off[2:1], 4'b0000};
        end else if (|(op_q & M_WORD)) begin
            dmem_be    = off[2] ? 8'hF0 : 8'h0F;
            dmem_wdata = off[2] ? {wd_q[31:0], 32'h0} : {32'h0, wd_q[31:0]};
        end else if (|(op_q & M_DW)) begin
            dmem_be    = 8'hFF;
            dmem_wdata = wd_q;
        end
    end

    assign sh_b = dmem_rdata >> {off, 3'b000};
    assign sh_h = dmem_rdata >> {off[2:1], 4'b0000};
    assign word = off[2] ? dmem_rdata[63:32] : dmem_rdata[31:0];

    always_comb begin
        load_val = 64'h0;
        case (1'b1)
            op_q[1]:  load_val = {{56{sh_b[7]}}, sh_b[7:0]};
            op_q[2]:  load_val = {56'h0, sh_b[7:0]};
            op_q[3]:  load_val = {{48{sh_h[15]}}, sh_h[15:0]};
            op_q[4]:  load_val = {48'h0, sh_h[15:0]};
            op_q[5]:  load_val = {{32{word[31]}}, word};
            op_q[10]: load_val = {32'h0, word};
            op_q[6]:  load_val = dmem_rdata;
            default:  load_val = 64'h0;
        endcase
    end

    assign mem_stall = (state != S_IDLE);
    assign dmem_req  = (state == S_REQ);
    assign dmem_addr = {res_q[ADDR_W-1:3], 3'b000};
    assign dmem_wen  = |(op_q & M_STORE);
    assign fwd_we    = wb_valid && wb_we;
    assign fwd_rd    = wb_rd;
    assign fwd_data  = wb_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            pc_q      <= '0;
            ebreak_q  <= 1'b0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            res_q     <= '0;
            wd_q      <= '0;
            cnt       <= '0;
            mem_err   <= 1'b0;
            wb_valid  <= 1'b0;
            wb_pc     <= '0;
            wb_ebreak <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= (state == S_IDLE) ? 8'h00 : cnt + 8'h01;
            wb_valid <= 1'b0;
            if (timeout) mem_err <= 1'b1;

            if (state == S_IDLE && ex_valid) begin
                op_q     <= ex_mem_onehot;
                pc_q     <= ex_pc;
                ebreak_q <= ex_ebreak;
                we_q     <= ex_we;
                rd_q     <= ex_rd;
                res_q    <= ex_result;
                wd_q     <= ex_wdata;
                if (!(|ex_mem_onehot)) begin
                    wb_valid  <= 1'b1;
                    wb_pc     <= ex_pc;
                    wb_ebreak <= ex_ebreak;
                    wb_we     <= ex_we;
                    wb_rd     <= ex_rd;
                    wb_data   <= (ex_rd == 5'd0) ? 64'h0 : ex_result;
                end
            end

            if (done) begin
                wb_valid  <= 1'b1;
                wb_pc     <= pc_q;
                wb_ebreak <= ebreak_q;
                wb_we     <= we_q;
                wb_rd     <= rd_q;
                if (rd_q == 5'd0)            wb_data <= 64'h0;
                else if (|(op_q & M_STORE))  wb_data <= res_q;
                else                         wb_data <= load_val;
            end

            // Abandoned access: emit a non-writing bubble so downstream drains
            if (timeout) begin
                wb_valid  <= 1'b1;
                wb_pc     <= pc_q;
                wb_ebreak <= ebreak_q;
                wb_we     <= 1'b0;
                wb_rd     <= rd_q;
                wb_data   <= 64'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: non-memory ops, load/store lanes, stalls,
// reset during an access and the timeout path (TIMEOUT=4).
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [10:0] ex_mem_onehot;
    logic [31:0] ex_pc;
    logic        ex_ebreak;
    logic        ex_we;
    logic [4:0]  ex_rd;
    logic [63:0] ex_result;
    logic [63:0] ex_wdata;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_ready;
    logic [31:0] dmem_addr;
    logic        dmem_wen;
    logic [7:0]  dmem_be;
    logic [63:0] dmem_wdata;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_ebreak;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        fwd_we;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    mem_stage #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_onehot(ex_mem_onehot),
        .ex_pc(ex_pc), .ex_ebreak(ex_ebreak), .ex_we(ex_we), .ex_rd(ex_rd),
        .ex_result(ex_result), .ex_wdata(ex_wdata), .mem_stall(mem_stall),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr),
        .dmem_wen(dmem_wen), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_pc(wb_pc), .wb_ebreak(wb_ebreak), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mem_op(input logic [10:0] oh, input logic [63:0] res, input logic [63:0] wd,
                          input logic [4:0] rd, input logic we, input logic [63:0] rdata,
                          input int dly, input logic [7:0] ebe, input logic [63:0] ewd,
                          input logic ewen, input logic [63:0] ewb);
        ex_valid = 1'b1; ex_mem_onehot = oh; ex_result = res; ex_wdata = wd;
        ex_rd = rd; ex_we = we; ex_pc = 32'h0000_2000;
        tick();
        ex_valid = 1'b0; ex_mem_onehot = '0; ex_result = ~res; ex_wdata = ~wd;
        chk("acc_wb_valid", wb_valid, 0);
        for (int i = 0; i < dly; i++) begin
            chk("hold_req", dmem_req, 1);
            chk("hold_stall", mem_stall, 1);
            chk("hold_addr", dmem_addr, {res[31:3], 3'b000});
            tick();
        end
        chk("req", dmem_req, 1);
        chk("req_stall", mem_stall, 1);
        chk("addr", dmem_addr, {res[31:3], 3'b000});
        chk("be", dmem_be, ebe);
        chk("wdata", dmem_wdata, ewd);
        chk("wen", dmem_wen, ewen);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        chk("wait_req", dmem_req, 0);
        chk("wait_stall", mem_stall, 1);
        chk("wait_wb_valid", wb_valid, 0);
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        chk("done_wb_valid", wb_valid, 1);
        chk("done_wb_data", wb_data, ewb);
        chk("done_wb_rd", wb_rd, rd);
        chk("done_wb_we", wb_we, we);
        chk("done_wb_pc", wb_pc, 32'h0000_2000);
        chk("done_fwd_data", fwd_data, ewb);
        chk("done_stall", mem_stall, 0);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 0; ex_mem_onehot = '0; ex_pc = '0; ex_ebreak = 0;
        ex_we = 0; ex_rd = '0; ex_result = '0; ex_wdata = '0;
        dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = '0;
        tick(); tick();
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_fwd_we", fwd_we, 0);
        rst = 1'b0;

        // rvalid while idle must be ignored
        dmem_rvalid = 1'b1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        dmem_rvalid = 1'b0;
        chk("idle_rvalid_wb_valid", wb_valid, 0);
        chk("idle_rvalid_stall", mem_stall, 0);

        // Back-to-back non-memory ops
        ex_valid = 1; ex_mem_onehot = '0; ex_result = 64'h1234; ex_rd = 5; ex_we = 1;
        ex_pc = 32'h0000_1000; ex_ebreak = 0;
        tick();
        chk("alu1_wb_valid", wb_valid, 1);
        chk("alu1_wb_data", wb_data, 64'h1234);
        chk("alu1_fwd_rd", fwd_rd, 5);
        chk("alu1_fwd_we", fwd_we, 1);
        chk("alu1_wb_pc", wb_pc, 32'h0000_1000);
        chk("alu1_stall", mem_stall, 0);
        ex_result = 64'h55; ex_rd = 6; ex_pc = 32'h0000_1004; ex_ebreak = 1;
        tick();
        chk("alu2_wb_data", wb_data, 64'h55);
        chk("alu2_wb_rd", wb_rd, 6);
        chk("alu2_ebreak", wb_ebreak, 1);
        chk("alu2_stall", mem_stall, 0);
        ex_ebreak = 0; ex_result = 64'h77; ex_rd = 0;
        tick();
        chk("alu_rd0_data", wb_data, 0);
        ex_valid = 0;
        tick();
        chk("bubble_wb_valid", wb_valid, 0);
        chk("bubble_fwd_we", fwd_we, 0);
        chk("bubble_wb_rd_hold", wb_rd, 0);

        // oh                res                  wdata                   rd we rdata                   dly be     wdata                   wen wb
        mem_op(11'b000_0000_0010, 64'h8000_0003, 64'h0, 5'd7, 1, 64'h0000_0000_8000_0000, 0, 8'h08, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FF80);
        mem_op(11'b000_0000_0100, 64'h8000_0003, 64'h0, 5'd7, 1, 64'h0000_0000_8000_0000, 0, 8'h08, 64'h0, 0, 64'h0000_0000_0000_0080);
        mem_op(11'b010_0000_0000, 64'h8000_0006, 64'hABCD, 5'd9, 0, 64'hDEAD, 3, 8'hC0, 64'hABCD_0000_0000_0000, 1, 64'h8000_0006);
        mem_op(11'b000_0010_0000, 64'h8000_0004, 64'h0, 5'd10, 1, 64'h8765_4321_0000_0000, 0, 8'hF0, 64'h0, 0, 64'hFFFF_FFFF_8765_4321);
        mem_op(11'b100_0000_0000, 64'h8000_0004, 64'h0, 5'd10, 1, 64'h8765_4321_0000_0000, 0, 8'hF0, 64'h0, 0, 64'h0000_0000_8765_4321);
        mem_op(11'b000_0010_0000, 64'h8000_0004, 64'h0, 5'd0, 1, 64'h8765_4321_0000_0000, 0, 8'hF0, 64'h0, 0, 64'h0);
        mem_op(11'b000_0000_1000, 64'h8000_0002, 64'h0, 5'd11, 1, 64'h0000_0000_8001_0000, 0, 8'h0C, 64'h0, 0, 64'hFFFF_FFFF_FFFF_8001);
        mem_op(11'b001_0000_0000, 64'h8000_0010, 64'h1122_3344_5566_7788, 5'd12, 0, 64'h0, 1, 8'hFF, 64'h1122_3344_5566_7788, 1, 64'h8000_0010);
        mem_op(11'b000_0100_0000, 64'h8000_0018, 64'h0, 5'd13, 1, 64'hCAFE_F00D_1234_5678, 0, 8'hFF, 64'h0, 0, 64'hCAFE_F00D_1234_5678);
        mem_op(11'b000_0000_0001, 64'h8000_0005, 64'h0000_0000_0000_115A, 5'd14, 0, 64'h0, 0, 8'h20, 64'h0000_5A00_0000_0000, 1, 64'h8000_0005);
        tick();
        chk("post_mem_wb_valid", wb_valid, 0);

        // Reset while waiting for the response; late rvalid must not complete
        ex_valid = 1; ex_mem_onehot = 11'b000_0000_0010; ex_result = 64'h8000_0003; ex_rd = 7; ex_we = 1;
        tick();
        ex_valid = 0; ex_mem_onehot = '0;
        dmem_ready = 1;
        tick();
        dmem_ready = 0;
        chk("rstw_in_wait", mem_stall, 1);
        rst = 1;
        tick();
        rst = 0;
        dmem_rvalid = 1; dmem_rdata = 64'h0000_0000_8000_0000;
        tick();
        dmem_rvalid = 0;
        chk("rstw_stall", mem_stall, 0);
        chk("rstw_req", dmem_req, 0);
        chk("rstw_wb_valid", wb_valid, 0);
        chk("rstw_wb_data", wb_data, 0);
        chk("rstw_addr", dmem_addr, 0);
        tick();
        chk("rstw_wb_valid2", wb_valid, 0);

        // Timeout: ready never arrives
        ex_valid = 1; ex_mem_onehot = 11'b000_0000_0010; ex_result = 64'h8000_0040; ex_rd = 8; ex_we = 1;
        tick();
        ex_valid = 0; ex_mem_onehot = '0;
        tick(); tick(); tick();
        chk("to_pre_err", mem_err, 0);
        chk("to_pre_stall", mem_stall, 1);
        chk("to_pre_req", dmem_req, 1);
        tick();
        chk("to_err", mem_err, 1);
        chk("to_stall", mem_stall, 0);
        chk("to_req", dmem_req, 0);
        chk("to_wb_valid", wb_valid, 1);
        chk("to_wb_we", wb_we, 0);
        chk("to_fwd_we", fwd_we, 0);
        tick();
        chk("to_wb_valid_drop", wb_valid, 0);
        chk("to_err_sticky", mem_err, 1);
        ex_valid = 1; ex_result = 64'h99; ex_rd = 3; ex_we = 1;
        tick();
        ex_valid = 0;
        chk("to_after_alu", wb_data, 64'h99);
        chk("to_after_err", mem_err, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("to_err_cleared", mem_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the npc five-stage RV64 pipeline, directly downstream of EX.
- Latches the EX→MEM bundle and owns the data-memory request/response handshake.
- Lane-shifts store data, extracts and extends load data, and produces the registered MEM→WB bundle plus a combinational MEM→ID forwarding bus.
- Stalls upstream while an access is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width.
- TIMEOUT, 255, maximum cycles in REQ+WAIT before mem_err; 8-bit counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX bundle valid
- ex_mem_onehot  in  11  {lwu,sh,sd,sw,ld,lw,lhu,lh,lbu,lb,sb}; all zero means non-memory op
- ex_pc  in  32  instruction address
- ex_ebreak  in  1  ebreak marker
- ex_we  in  1  register write enable
- ex_rd  in  5  destination register
- ex_result  in  64  ALU result; effective address for load/store
- ex_wdata  in  64  store source (rs2), unshifted
- mem_stall  out  1  hold EX/ID/IF
- dmem_req  out  1  request valid
- dmem_ready  in  1  request accepted
- dmem_addr  out  ADDR_W  8-byte-aligned address
- dmem_wen  out  1  store
- dmem_be  out  8  byte enables, active high
- dmem_wdata  out  64  lane-shifted store data
- dmem_rvalid  in  1  response (load data or store ack)
- dmem_rdata  in  64  aligned doubleword
- wb_valid, wb_pc[32], wb_ebreak, wb_we, wb_rd[5], wb_data[64]  out  registered MEM→WB bundle
- fwd_we, fwd_rd[5], fwd_data[64]  out  forwarding from wb registers
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0; mem_err 0.
  - Reset mid-access: dmem_req drops next cycle.
  - A dmem_rvalid arriving in IDLE is ignored.
- States:
  - IDLE: accept input; stall 0.
  - REQ: dmem_req=1; address, wen, be and wdata held stable until dmem_req&&dmem_ready, then go to WAIT.
  - WAIT: on dmem_rvalid, write wb and go to IDLE.
  - mem_stall = (state != IDLE), combinational.
- Acceptance: in IDLE, an edge with ex_valid latches the bundle.
  - Non-memory op: wb_* updated at that same edge. Latency 1; one instruction per cycle.
  - Memory op: go to REQ. wb_valid is 0 until completion.
  - ex_valid=0 in IDLE: wb_valid←0, other wb fields hold.
- Ready/rvalid: ready and rvalid in the same cycle as the REQ handshake are not allowed. rvalid is honoured only in WAIT.
- Address: dmem_addr = {ex_result[ADDR_W-1:3],3'b0}. Offset o = ex_result[2:0].
- Byte enables and store data:
  - byte ops: be = 1<<o; wdata = ex_wdata[7:0]<<(8*o).
  - half ops: be = 2'b11<<(2*o[2:1]); wdata = ex_wdata[15:0]<<(16*o[2:1]); o[0] is ignored.
  - word ops: be = o[2] ? F0 : 0F; wdata = ex_wdata[31:0]<<(32*o[2]).
  - doubleword ops: be = FF; wdata = ex_wdata.
- Load data: lane selected by the same rules. lb/lh/lw sign-extend to 64 bits; lbu/lhu/lwu zero-extend; ld passes through.
- Stores: on completion, wb_data = latched ex_result and wb_we = latched ex_we.
- rd==0: wb_data forced 0 regardless of load data.
- fwd_we = wb_valid&&wb_we; fwd_rd = wb_rd; fwd_data = wb_data.
- Timeout: counter increments each cycle in REQ/WAIT and clears in IDLE. When it reaches TIMEOUT:
  - mem_err←1 (sticky until reset);
  - state←IDLE;
  - wb_valid←1 with wb_we←0 so the pipeline drains.

Test Plan:
- Non-memory op: ex_result=0x1234, rd=5, we=1 → wb_valid one edge later with wb_data=0x1234 and fwd_rd=5. mem_stall stays 0 across back-to-back ops.
- lb at addr 0x80000003, rdata=0x00000000_80000000 → dmem_addr=0x80000000, be=0x08, wb_data=0xFFFFFFFF_FFFFFF80. The same access as lbu gives 0x80.
- sh at offset 6, ex_wdata=0xABCD → be=0xC0, wdata=0xABCD0000_00000000, wen=1. dmem_ready delayed 3 cycles → req/addr held stable and mem_stall high throughout.
- lw at offset 4, rdata=0x87654321_00000000 → wb_data=0xFFFFFFFF_87654321. lwu → 0x00000000_87654321. With rd=0 → wb_data=0.
- rst asserted in WAIT, then dmem_rvalid the following cycle → state IDLE, outputs 0, no wb_valid pulse.
- dmem_ready held 0 with TIMEOUT=4 → mem_err=1 after 4 cycles, mem_stall released, and a wb_valid pulse with wb_we=0.
